hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the 5-stage MIPS core: the decision side of the ID/EX interface. It reads the control and register fields that the ID/EX buffer has latched, together with the IF/ID decode fields. From these it drives the write-enable, bubble and flush inputs of the PC and of every inter-stage buffer (IF/ID, ID/EX, EX/MEM, MEM/WB). It handles load-use stalls, taken-branch flushes and multi-cycle data-memory waits, with a timeout watchdog and hazard performance counters.

## Interface
Parameters:
- `TIMEOUT`, default 64. Maximum consecutive wait cycles on a data-memory access before the watchdog fires.
- `CNT_W`, default 16. Width of the performance counters.

Ports:
- `clk_HZ`, in, 1. Single clock; all state updates on posedge.
- `rst_n_HZ`, in, 1. Reset, asynchronous, active-low.
- `rs_ID`, in, 5. rs field of the instruction in IF/ID.
- `rt_ID`, in, 5. rt field of the instruction in IF/ID.
- `uses_rt_ID`, in, 1. The IF/ID instruction reads rt (R-type, beq, sw).
- `M_EX`, in, 3. Latched M field from ID/EX: [2]=Branch, [1]=MemRead, [0]=MemWrite.
- `rt_EX`, in, 5. Latched rt from ID/EX (load destination).
- `branch_taken_MEM`, in, 1. Branch resolved taken at EX/MEM output.
- `dmem_req_MEM`, in, 1. MEM stage holds a load or store.
- `dmem_ack`, in, 1. Data memory has completed the access this cycle.
- `pc_write`, out, 1. PC write enable.
- `ifid_write`, out, 1. IF/ID write enable.
- `idex_write`, out, 1. ID/EX write enable.
- `exmem_write`, out, 1. EX/MEM write enable.
- `idex_bubble`, out, 1. Load zeros into the ID/EX M/EX/WB fields.
- `ifid_flush`, out, 1. Clear IF/ID to a nop.
- `idex_flush`, out, 1. Clear ID/EX to a nop.
- `memwb_bubble`, out, 1. Load zeros into the MEM/WB WB field.
- `mem_err`, out, 1. Sticky watchdog flag.
- `hz_state`, out, 2. Current FSM state encoding.
- `stall_cnt`, out, CNT_W. Number of load-use stall cycles.
- `flush_cnt`, out, CNT_W. Number of taken-branch flushes.
- `wait_cnt`, out, CNT_W. Number of memory wait cycles.

## Operation
- FSM states: RUN=0, FLUSH=1, MEM_WAIT=2. Encoding 3 is illegal and recovers to RUN on the next edge.
- Defaults (RUN, no hazard):
  - All write enables = 1.
  - All bubble and flush outputs = 0.
- Event priority in RUN: memory wait > branch flush > load-use.

Memory wait:
- Condition: `dmem_req_MEM` && !`dmem_ack`.
- Response, same cycle (Mealy): all write enables = 0 and `memwb_bubble` = 1.
- Next state MEM_WAIT.
- In MEM_WAIT, the same outputs are held until `dmem_ack` = 1. The ack cycle releases the writes and drops `memwb_bubble`; next state RUN.

Watchdog:
- A wait counter counts cycles in MEM_WAIT.
- When it reaches `TIMEOUT` without ack: `mem_err` is set and the FSM returns to RUN with the writes released.
- `mem_err` clears only on reset.

Branch flush:
- Condition: `branch_taken_MEM` in RUN.
- Response, same cycle: `ifid_flush` = 1 and `idex_flush` = 1; all writes stay 1.
- Next state FLUSH, which lasts exactly one cycle. During that cycle:
  - Load-use detection is suppressed, because IF/ID and ID/EX now hold flushed nops.
  - A further `branch_taken_MEM` is ignored.
- After the FLUSH cycle the FSM returns to RUN.

Load-use:
- Condition, in RUN only: `M_EX[1]` && `rt_EX`!=0 && (`rt_EX`==`rs_ID` || (`uses_rt_ID` && `rt_EX`==`rt_ID`)).
- Response, same cycle: `pc_write` = 0, `ifid_write` = 0, `idex_bubble` = 1.
- No state change. The condition clears naturally once the load advances to MEM.

Counters:
- 16-bit (CNT_W), saturating at all-ones, never wrap.
- `stall_cnt` increments by 1 per load-use cycle.
- `flush_cnt` increments by 1 per RUN→FLUSH transition.
- `wait_cnt` increments by 1 per cycle in which memory-wait outputs are asserted, including the entry cycle.

## Timing
- All control outputs are combinational from the current state and current inputs, so they take effect at the edge that would otherwise capture the bad data.
- `hz_state`, the counters and `mem_err` are registered.
- Reset:
  - Takes effect immediately and asynchronously: state = RUN, counters = 0, `mem_err` = 0, watchdog counter = 0.
  - While `rst_n_HZ` = 0, outputs are forced to the RUN defaults and all hazard inputs are ignored.
  - Reset asserted mid-MEM_WAIT or mid-FLUSH aborts that state without setting `mem_err`.
- Simultaneous events:
  - A memory wait together with a taken branch: the wait wins. The flush is taken on the ack cycle if `branch_taken_MEM` is still high, because the frozen EX/MEM holds it.
  - A load-use hazard coincident with a branch flush is dropped.

## Structure
- The shared pipeline package holds:
  - state enum `hz_state_t`;
  - M-field bit index constants (`M_BRANCH`=2, `M_MEMREAD`=1, `M_MEMWRITE`=0);
  - `REG_ZERO`=5'd0.
- One sub-module, `sat_counter`, parameterised by width with `inc` and `clr` inputs. It is instantiated three times.
- Detection logic and the FSM stay inline.

## Test plan
1. Load-use on rs:
   - Stimulus: `M_EX`=3'b010, `rt_EX`=5, `rs_ID`=5, for 1 cycle.
   - Response: `pc_write`=0, `ifid_write`=0, `idex_bubble`=1 for exactly 1 cycle; `stall_cnt`=1.
   - Repeat with `rt_EX`=0: no stall.
2. rt dependency gated by `uses_rt_ID`:
   - Stimulus: `rt_EX`=7=`rt_ID`.
   - Response: `uses_rt_ID`=0 gives no stall; `uses_rt_ID`=1 gives a stall.
3. Taken branch:
   - Stimulus: `branch_taken_MEM`=1 for 2 cycles, with a load-use condition present on the second cycle.
   - Response: `ifid_flush`=`idex_flush`=1 on the first cycle only; `hz_state`=1 then 0; no stall; `flush_cnt`=1.
4. Memory wait of 3 cycles:
   - Stimulus: `dmem_req_MEM`=1, `dmem_ack`=0 for 3 cycles, then ack=1.
   - Response: all writes = 0 and `memwb_bubble`=1 for 3 cycles, released on the ack cycle; `wait_cnt`=3.
5. Watchdog:
   - Stimulus: `TIMEOUT`=4, request held with no ack.
   - Response: `mem_err`=1 after 4 wait cycles, FSM back in RUN, `mem_err` stays set until `rst_n_HZ` pulses low.
6. Reset and saturation:
   - Reset asserted in MEM_WAIT gives immediate RUN defaults with `mem_err`=0.
   - With `CNT_W`=4, 20 stall cycles leave `stall_cnt`=15.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions used by the hazard controller:
// FSM state encoding, ID/EX M-field bit positions and register constants.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    HZ_RUN      = 2'd0,
    HZ_FLUSH    = 2'd1,
    HZ_MEM_WAIT = 2'd2
  } hz_state_t;

  localparam int M_BRANCH   = 2;
  localparam int M_MEMREAD  = 1;
  localparam int M_MEMWRITE = 0;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // A genuine load reads memory and neither writes it nor branches.
  function automatic logic is_load(input logic [2:0] m);
    return m[M_MEMREAD] & ~m[M_MEMWRITE] & ~m[M_BRANCH];
  endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  // Count register: clear wins over increment, increment stops at all-ones.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and data-memory
// waits with a watchdog, driving PC and inter-stage buffer enables combinationally.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk_HZ,
  input  logic             rst_n_HZ,
  input  logic [4:0]       rs_ID,
  input  logic [4:0]       rt_ID,
  input  logic             uses_rt_ID,
  input  logic [2:0]       M_EX,
  input  logic [4:0]       rt_EX,
  input  logic             branch_taken_MEM,
  input  logic             dmem_req_MEM,
  input  logic             dmem_ack,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             exmem_write,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_bubble,
  output logic             mem_err,
  output logic [1:0]       hz_state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] wait_cnt
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic [WD_W-1:0] r_wd;
  logic            r_mem_err;

  logic w_in_run;
  logic w_in_wait;
  logic w_run_eval;
  logic w_wait;
  logic w_expire;
  logic w_flush;
  logic w_hazard;
  logic w_stall;

  assign w_in_run  = (r_state == HZ_RUN);
  assign w_in_wait = (r_state == HZ_MEM_WAIT);
  // The ack cycle of a wait is evaluated like RUN so a held branch flushes there.
  assign w_run_eval = w_in_run || (w_in_wait && dmem_ack);

  // Once the watchdog has fired the memory is treated as dead and no longer stalls.
  assign w_wait   = rst_n_HZ && !r_mem_err &&
                    ((w_in_run && dmem_req_MEM && !dmem_ack) || (w_in_wait && !dmem_ack));
  assign w_expire = w_wait && (r_wd == WD_LAST);
  assign w_flush  = rst_n_HZ && w_run_eval && branch_taken_MEM && !w_wait;
  assign w_hazard = is_load(M_EX) && (rt_EX != REG_ZERO) &&
                    ((rt_EX == rs_ID) || (uses_rt_ID && (rt_EX == rt_ID)));
  assign w_stall  = rst_n_HZ && w_run_eval && !w_wait && !w_flush && w_hazard;

  // State register.
  always_ff @(posedge clk_HZ or negedge rst_n_HZ) begin
    if (!rst_n_HZ) begin
      r_state <= HZ_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; the unused encoding falls back to RUN.
  always_comb begin
    w_state_nxt = HZ_RUN;
    case (r_state)
      HZ_RUN, HZ_MEM_WAIT: begin
        if (w_wait && !w_expire) begin
          w_state_nxt = HZ_MEM_WAIT;
        end else if (w_flush) begin
          w_state_nxt = HZ_FLUSH;
        end else begin
          w_state_nxt = HZ_RUN;
        end
      end
      HZ_FLUSH: w_state_nxt = HZ_RUN;
      default:  w_state_nxt = HZ_RUN;
    endcase
  end

  // Output decode; the three hazard responses are mutually exclusive by construction.
  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    idex_write   = 1'b1;
    exmem_write  = 1'b1;
    idex_bubble  = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    memwb_bubble = 1'b0;
    if (w_wait) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_write   = 1'b0;
      exmem_write  = 1'b0;
      memwb_bubble = 1'b1;
    end else if (w_flush) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (w_stall) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end else begin
      pc_write = 1'b1;
    end
  end

  // Watchdog: counts wait cycles of the current episode, including the entry cycle.
  always_ff @(posedge clk_HZ or negedge rst_n_HZ) begin
    if (!rst_n_HZ) begin
      r_wd      <= '0;
      r_mem_err <= 1'b0;
    end else begin
      r_wd      <= (w_wait && !w_expire) ? r_wd + WD_W'(1) : '0;
      r_mem_err <= r_mem_err | w_expire;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .i_clk(clk_HZ), .i_rst_n(rst_n_HZ), .i_inc(w_stall), .i_clr(1'b0), .o_cnt(stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .i_clk(clk_HZ), .i_rst_n(rst_n_HZ), .i_inc(w_flush), .i_clr(1'b0), .o_cnt(flush_cnt)
  );

  sat_counter #(.W(CNT_W)) u_wait_cnt (
    .i_clk(clk_HZ), .i_rst_n(rst_n_HZ), .i_inc(w_wait), .i_clr(1'b0), .o_cnt(wait_cnt)
  );

  assign hz_state = r_state;
  assign mem_err  = r_mem_err;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed, table-driven bench for hazard_ctrl with a short watchdog and 4-bit counters.
module tb_hazard_ctrl;

  localparam int TO = 4;
  localparam int CW = 4;

  // Control output vectors: {pc, ifid, idex, exmem, idex_bubble, ifid_flush, idex_flush, memwb_bubble}
  localparam logic [7:0] DEF = 8'hF0;
  localparam logic [7:0] STL = 8'h38;
  localparam logic [7:0] FLS = 8'hF6;
  localparam logic [7:0] WAI = 8'h01;

  logic          clk_HZ = 1'b0;
  logic          rst_n_HZ;
  logic [4:0]    rs_ID, rt_ID, rt_EX;
  logic          uses_rt_ID, branch_taken_MEM, dmem_req_MEM, dmem_ack;
  logic [2:0]    M_EX;
  logic          pc_write, ifid_write, idex_write, exmem_write;
  logic          idex_bubble, ifid_flush, idex_flush, memwb_bubble, mem_err;
  logic [1:0]    hz_state;
  logic [CW-1:0] stall_cnt, flush_cnt, wait_cnt;
  logic [7:0]    outs;

  hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk_HZ(clk_HZ), .rst_n_HZ(rst_n_HZ),
    .rs_ID(rs_ID), .rt_ID(rt_ID), .uses_rt_ID(uses_rt_ID),
    .M_EX(M_EX), .rt_EX(rt_EX),
    .branch_taken_MEM(branch_taken_MEM), .dmem_req_MEM(dmem_req_MEM), .dmem_ack(dmem_ack),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
    .exmem_write(exmem_write), .idex_bubble(idex_bubble), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .memwb_bubble(memwb_bubble), .mem_err(mem_err),
    .hz_state(hz_state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wait_cnt(wait_cnt)
  );

  assign outs = {pc_write, ifid_write, idex_write, exmem_write,
                 idex_bubble, ifid_flush, idex_flush, memwb_bubble};

  always #5 clk_HZ = ~clk_HZ;

  typedef struct {
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic          uses;
    logic [2:0]    m;
    logic [4:0]    rtex;
    logic          br;
    logic          req;
    logic          ack;
    logic [7:0]    outs;
    logic [1:0]    st;
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
    logic [CW-1:0] wc;
  } vec_t;

  vec_t vt[21];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                       input logic [2:0] m, input logic [4:0] rtex,
                       input logic br, input logic req, input logic ack);
    rs_ID = rs; rt_ID = rt; uses_rt_ID = uses; M_EX = m; rt_EX = rtex;
    branch_taken_MEM = br; dmem_req_MEM = req; dmem_ack = ack;
  endtask

  // Advance to just after the next edge, apply inputs, then settle to mid-cycle.
  task automatic step(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                      input logic [2:0] m, input logic [4:0] rtex,
                      input logic br, input logic req, input logic ack);
    @(posedge clk_HZ);
    #1;
    drive(rs, rt, uses, m, rtex, br, req, ack);
    #3;
  endtask

  task automatic reset_pulse();
    @(posedge clk_HZ);
    #2;
    drive(5'd0, 5'd0, 1'b0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b0);
    rst_n_HZ = 1'b0;
    #2;
    rst_n_HZ = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{5'd0, 5'd0, 1'b0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b0, DEF, 2'd0, 4'd0, 4'd0, 4'd0};
    vt[1]  = '{5'd5, 5'd0, 1'b0, 3'b010, 5'd5, 1'b0, 1'b0, 1'b0, STL, 2'd0, 4'd0, 4'd0, 4'd0};
    vt[2]  = '{5'd0, 5'd0, 1'b0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b0, DEF, 2'd0, 4'd1, 4'd0, 4'd0};
    vt[3]  = '{5'd0, 5'd0, 1'b0, 3'b010, 5'd0, 1'b0, 1'b0, 1'b0, DEF, 2'd0, 4'd1, 4'd0, 4'd0};
    vt[4]  = '{5'd3, 5'd7, 1'b0, 3'b010, 5'd7, 1'b0, 1'b0, 1'b0, DEF, 2'd0, 4'd1, 4'd0, 4'd0};
    vt[5]  = '{5'd3, 5'd7, 1'b1, 3'b010, 5'd7, 1'b0, 1'b0, 1'b0, STL, 2'd0, 4'd1, 4'd0, 4'd0};
    vt[6]  = '{5'd0, 5'd0, 1'b0, 3'b000, 5'd0, 1'b1, 1'b0, 1'b0, FLS, 2'd0, 4'd2, 4'd0, 4'd0};
    vt[7]  = '{5'd5, 5'd0, 1'b0, 3'b010, 5'd5, 1'b1, 1'b0, 1'b0, DEF, 2'd1, 4'd2, 4'd1, 4'd0};
    vt[8]  = '{5'd0, 5'd0, 1'b0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b0, DEF, 2'd0, 4'd2, 4'd1, 4'd0};
    vt[9]  = '{5'd0, 5'd0, 1'b0, 3'b000, 5'd0, 1'b0, 1'b1, 1'b0, WAI, 2'd0, 4'd2, 4'd1, 4'd0};
    vt[10] = '{5'd0, 5'd0, 1'b0, 3'b000, 5'd0, 1'b0, 1'b1, 1'b0, WAI, 2'd2, 4'd2, 4'd1, 4'd1};
    vt[11] = '{5'd0, 5'd0, 1'b0, 3'b000, 5'd0, 1'b0, 1'b1, 1'b0, WAI, 2'd2, 4'd2, 4'd1, 4'd2};
    vt[12] = '{5'd0, 5'd0, 1'b0, 3'b000, 5'd0, 1'b0, 1'b1, 1'b1, DEF, 2'd2, 4'd2, 4'd1, 4'd3};
    vt[13] = '{5'd0, 5'd0, 1'b0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b0, DEF, 2'd0, 4'd2, 4'd1, 4'd3};
    vt[14] = '{5'd5, 5'd0, 1'b0, 3'b010, 5'd5, 1'b1, 1'b1, 1'b0, WAI, 2'd0, 4'd2, 4'd1, 4'd3};
    vt[15] = '{5'd5, 5'd0, 1'b0, 3'b010, 5'd5, 1'b1, 1'b1, 1'b1, FLS, 2'd2, 4'd2, 4'd1, 4'd4};
    vt[16] = '{5'd0, 5'd0, 1'b0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b0, DEF, 2'd1, 4'd2, 4'd2, 4'd4};
    vt[17] = '{5'd0, 5'd0, 1'b0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b0, DEF, 2'd0, 4'd2, 4'd2, 4'd4};
    vt[18] = '{5'd5, 5'd0, 1'b0, 3'b010, 5'd5, 1'b1, 1'b0, 1'b0, FLS, 2'd0, 4'd2, 4'd2, 4'd4};
    vt[19] = '{5'd0, 5'd0, 1'b0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b0, DEF, 2'd1, 4'd2, 4'd3, 4'd4};
    vt[20] = '{5'd0, 5'd0, 1'b0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b0, DEF, 2'd0, 4'd2, 4'd3, 4'd4};

    // Reset with every hazard input active: outputs must sit at RUN defaults.
    rst_n_HZ = 1'b0;
    drive(5'd5, 5'd0, 1'b0, 3'b010, 5'd5, 1'b1, 1'b1, 1'b0);
    #7;
    chk("reset_outs", outs, DEF);
    chk("reset_state", hz_state, 2'd0);
    chk("reset_err", mem_err, 1'b0);
    chk("reset_cnts", {stall_cnt, flush_cnt, wait_cnt}, 12'h000);
    drive(5'd0, 5'd0, 1'b0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    rst_n_HZ = 1'b1;

    for (int i = 0; i < 21; i++) begin
      step(vt[i].rs, vt[i].rt, vt[i].uses, vt[i].m, vt[i].rtex, vt[i].br, vt[i].req, vt[i].ack);
      chk($sformatf("v%0d_outs", i), outs, vt[i].outs);
      chk($sformatf("v%0d_state", i), hz_state, vt[i].st);
      chk($sformatf("v%0d_stall_cnt", i), stall_cnt, vt[i].sc);
      chk($sformatf("v%0d_flush_cnt", i), flush_cnt, vt[i].fc);
      chk($sformatf("v%0d_wait_cnt", i), wait_cnt, vt[i].wc);
    end
    chk("table_err", mem_err, 1'b0);

    // Watchdog: request held with no ack for TIMEOUT wait cycles.
    reset_pulse();
    for (int i = 0; i < TO; i++) begin
      step(5'd0, 5'd0, 1'b0, 3'b000, 5'd0, 1'b0, 1'b1, 1'b0);
      chk($sformatf("wd%0d_outs", i), outs, WAI);
      chk($sformatf("wd%0d_state", i), hz_state, (i == 0) ? 2'd0 : 2'd2);
      chk($sformatf("wd%0d_err", i), mem_err, 1'b0);
    end
    step(5'd0, 5'd0, 1'b0, 3'b000, 5'd0, 1'b0, 1'b1, 1'b0);
    chk("wd_fire_err", mem_err, 1'b1);
    chk("wd_fire_state", hz_state, 2'd0);
    chk("wd_fire_outs", outs, DEF);
    chk("wd_fire_wait_cnt", wait_cnt, 4'd4);
    step(5'd0, 5'd0, 1'b0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b0);
    step(5'd0, 5'd0, 1'b0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("wd_sticky_err", mem_err, 1'b1);
    reset_pulse();
    step(5'd0, 5'd0, 1'b0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("wd_cleared_err", mem_err, 1'b0);

    // Reset asserted while in MEM_WAIT aborts immediately.
    step(5'd0, 5'd0, 1'b0, 3'b000, 5'd0, 1'b0, 1'b1, 1'b0);
    step(5'd0, 5'd0, 1'b0, 3'b000, 5'd0, 1'b0, 1'b1, 1'b0);
    chk("mw_pre_state", hz_state, 2'd2);
    #1;
    rst_n_HZ = 1'b0;
    #1;
    chk("mw_rst_outs", outs, DEF);
    chk("mw_rst_state", hz_state, 2'd0);
    chk("mw_rst_err", mem_err, 1'b0);
    chk("mw_rst_wait_cnt", wait_cnt, 4'd0);
    drive(5'd0, 5'd0, 1'b0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    rst_n_HZ = 1'b1;

    // Saturation: 20 load-use cycles on a 4-bit counter.
    for (int i = 0; i < 20; i++) begin
      step(5'd9, 5'd0, 1'b0, 3'b010, 5'd9, 1'b0, 1'b0, 1'b0);
    end
    chk("sat_last_outs", outs, STL);
    step(5'd0, 5'd0, 1'b0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("sat_stall_cnt", stall_cnt, 4'd15);
    chk("sat_idle_outs", outs, DEF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
